// File: rtl/mdarb_pkg.sv
// Shared state encoding, operation codes and owner ids for multdiv_arbiter.
package mdarb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam logic OWNER_0 = 1'b0;
  localparam logic OWNER_1 = 1'b1;

endpackage

// File: rtl/multdiv_arbiter_rr_arb2.sv
// Two-input round-robin picker: on contention the requester not granted last time wins.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) grant = last_grant ? 2'b01 : 2'b10;
    else if (valid0)      grant = 2'b01;
    else if (valid1)      grant = 2'b10;
  end

endmodule

// File: rtl/multdiv_arbiter.sv
// Shares one multiplier/divider between two requesters: round-robin accept, start pulse, guarded wait, held response.
// Optional abort on a stuck unit is enabled with `define MDARB_TIMEOUT_EN.
module multdiv_arbiter
  import mdarb_pkg::*;
#(
  parameter int TAG_W          = 5,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_result,
  output logic             rsp0_exception,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_result,
  output logic             rsp1_exception,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic [31:0]      md_operandA,
  output logic [31:0]      md_operandB,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  input  logic [31:0]      md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  output logic             busy,
  output logic             timeout
);

  localparam int CNT_MAX = (GUARD_CYCLES > TIMEOUT_CYCLES) ? GUARD_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD_CYCLES);
`ifdef MDARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(TIMEOUT_CYCLES);
`else
  localparam logic [CNT_W-1:0] CNT_SAT = GUARD_C;
`endif

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               op_q, op_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        res_q, res_d;
  logic               exc_q, exc_d;
  logic               timeout_q, timeout_d;
  logic [1:0]         grant;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Ready is gated by reset_n so nothing handshakes while reset is asserted.
  assign req0_ready = reset_n && (state_q == ST_IDLE) && grant[0];
  assign req1_ready = reset_n && (state_q == ST_IDLE) && grant[1];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    tag_d        = tag_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    exc_d        = exc_q;
    timeout_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0_valid && req0_ready) begin
          op_d = req0_op; a_d = req0_a; b_d = req0_b; tag_d = req0_tag;
          owner_d = OWNER_0; last_grant_d = OWNER_0; state_d = ST_ISSUE;
        end else if (req1_valid && req1_ready) begin
          op_d = req1_op; a_d = req1_a; b_d = req1_b; tag_d = req1_tag;
          owner_d = OWNER_1; last_grant_d = OWNER_1; state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Ready seen during the guard window may be left over from an earlier or abandoned op.
        if ((cnt_q >= GUARD_C) && md_resultRDY) begin
          res_d   = md_result;
          exc_d   = md_exception;
          state_d = ST_RESP;
        end
`ifdef MDARB_TIMEOUT_EN
        else if (cnt_q == CNT_SAT) begin
          res_d     = '0;
          exc_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end
`endif
        else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if ((owner_q == OWNER_0) ? rsp0_ready : rsp1_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // Operand and response registers are reset too, since they drive outputs that must read 0 in reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWNER_1;
      op_q         <= OP_MULT;
      a_q          <= '0;
      b_q          <= '0;
      tag_q        <= '0;
      owner_q      <= OWNER_0;
      cnt_q        <= '0;
      res_q        <= '0;
      exc_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      tag_q        <= tag_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      exc_q        <= exc_d;
      timeout_q    <= timeout_d;
    end
  end

  assign md_operandA  = a_q;
  assign md_operandB  = b_q;
  assign md_ctrl_MULT = (state_q == ST_ISSUE) && (op_q == OP_MULT);
  assign md_ctrl_DIV  = (state_q == ST_ISSUE) && (op_q == OP_DIV);
  assign busy         = (state_q != ST_IDLE);
  assign timeout      = timeout_q;

  // The non-owner port reads all zeros.
  assign rsp0_valid     = (state_q == ST_RESP) && (owner_q == OWNER_0);
  assign rsp1_valid     = (state_q == ST_RESP) && (owner_q == OWNER_1);
  assign rsp0_result    = rsp0_valid ? res_q : '0;
  assign rsp1_result    = rsp1_valid ? res_q : '0;
  assign rsp0_exception = rsp0_valid && exc_q;
  assign rsp1_exception = rsp1_valid && exc_q;
  assign rsp0_tag       = rsp0_valid ? tag_q : '0;
  assign rsp1_tag       = rsp1_valid ? tag_q : '0;

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Self-checking bench for multdiv_arbiter: behavioural multdiv model, per-port scoreboards, directed scenarios.
// Define MDARB_TIMEOUT_EN for both RTL and bench to run the stuck-unit scenario.
`timescale 1ns/1ps
module tb_multdiv_arbiter;
  import mdarb_pkg::*;

  localparam int TAG_W   = 5;
  localparam int GUARD   = 2;
  localparam int TIMEOUT = 64;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic             req0_valid, req0_ready, req0_op, req1_valid, req1_ready, req1_op;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [TAG_W-1:0] req0_tag, req1_tag, rsp0_tag, rsp1_tag;
  logic             rsp0_valid, rsp0_ready, rsp0_exception, rsp1_valid, rsp1_ready, rsp1_exception;
  logic [31:0]      rsp0_result, rsp1_result, md_operandA, md_operandB, md_result;
  logic             md_ctrl_MULT, md_ctrl_DIV, md_exception, md_resultRDY, busy, timeout;

  multdiv_arbiter #(.TAG_W(TAG_W), .GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_exception(rsp0_exception), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_exception(rsp1_exception), .rsp1_tag(rsp1_tag),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .busy(busy), .timeout(timeout)
  );

  typedef struct {
    logic             op;
    logic [31:0]      a, b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      xres;
    logic             xexc;
  } req_t;

  typedef struct {
    logic [31:0]      res;
    logic             exc;
    logic [TAG_W-1:0] tag;
    int               acc_cyc;
  } exp_t;

  req_t rq0[$], rq1[$];
  exp_t ex0[$], ex1[$];
  int   grant_log[$];

  int checks = 0, failures = 0;
  int cyc = 0;
  int md_lat = 5;
  bit stale_mode = 0, never_ready = 0, hold0 = 0, b2b_chk = 0;
  int mult_cycles = 0, div_cycles = 0, timeout_cycles = 0;
  int last_lat = 0, last_consume = 0;
  logic [31:0] cur_a = '0, cur_b = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Arithmetic of the shared unit, used only by the behavioural unit model.
  function automatic void unit_calc(input logic op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e);
    logic signed [63:0] p;
    r = '0; e = 1'b0;
    if (op == OP_MULT) begin
      p = $signed(a) * $signed(b);
      r = p[31:0];
      e = (p != {{32{p[31]}}, p[31:0]});
    end else if (b == 32'd0) begin
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = a; e = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
    end
  endfunction

  task automatic push_req(input int p, input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input logic [31:0] xres, input logic xexc);
    req_t r;
    r.op = op; r.a = a; r.b = b; r.tag = tag; r.xres = xres; r.xexc = xexc;
    if (p == 0) rq0.push_back(r); else rq1.push_back(r);
  endtask

  task automatic accept(input int p);
    req_t r;
    exp_t e;
    if (p == 0) r = rq0.pop_front(); else r = rq1.pop_front();
    e.res = r.xres; e.exc = r.xexc; e.tag = r.tag; e.acc_cyc = cyc;
    if (p == 0) ex0.push_back(e); else ex1.push_back(e);
    cur_a = r.a; cur_b = r.b;
    grant_log.push_back(p);
    if (b2b_chk && grant_log.size() > 1) check("b2b_accept_gap", cyc - last_consume, 1);
  endtask

  task automatic drive_inputs();
    req0_valid = (rq0.size() > 0);
    req0_op  = req0_valid ? rq0[0].op  : 1'b0;
    req0_a   = req0_valid ? rq0[0].a   : '0;
    req0_b   = req0_valid ? rq0[0].b   : '0;
    req0_tag = req0_valid ? rq0[0].tag : '0;
    req1_valid = (rq1.size() > 0);
    req1_op  = req1_valid ? rq1[0].op  : 1'b0;
    req1_a   = req1_valid ? rq1[0].a   : '0;
    req1_b   = req1_valid ? rq1[0].b   : '0;
    req1_tag = req1_valid ? rq1[0].tag : '0;
    rsp0_ready = !hold0;
    rsp1_ready = 1'b1;
  endtask

  // Requester side: decide handshakes mid-cycle, update inputs just after the edge.
  initial begin : driver
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (req0_valid && req0_ready) accept(0);
        if (req1_valid && req1_ready) accept(1);
      end
      @(posedge clock); #1;
      drive_inputs();
    end
  end

  // Unit model: result after md_lat cycles; stale_mode keeps ready high through the next guard window.
  initial begin : unit_model
    int busy_cnt, stale_left;
    logic [31:0] pres;
    logic pexc;
    busy_cnt = 0; stale_left = 0; pres = '0; pexc = 1'b0;
    md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        busy_cnt = 0; stale_left = 0;
        md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
      end else begin
        if (stale_left > 0) begin
          stale_left--;
          if (stale_left == 0) md_resultRDY = 1'b0;
        end else if (md_resultRDY && !stale_mode) begin
          md_resultRDY = 1'b0;
        end
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            md_resultRDY = 1'b1; md_result = pres; md_exception = pexc;
          end
        end
        if (md_ctrl_MULT || md_ctrl_DIV) begin
          unit_calc(md_ctrl_DIV ? OP_DIV : OP_MULT, md_operandA, md_operandB, pres, pexc);
          busy_cnt = never_ready ? 0 : md_lat;
          if (stale_mode && md_resultRDY) stale_left = GUARD + 1;
        end
      end
    end
  end

  bit pv[2], pr[2];
  bit in_op = 0;

  task automatic rsp_mon(input int p, input logic v, input logic r, input logic [31:0] res,
                         input logic exc, input logic [TAG_W-1:0] tag);
    exp_t e;
    int sz;
    string nm;
    nm = (p == 0) ? "rsp0" : "rsp1";
    sz = (p == 0) ? ex0.size() : ex1.size();
    if (pv[p] && !pr[p]) check({nm, "_valid_held"}, 32'(v), 1);
    if (v) begin
      check({nm, "_pending"}, sz, 1);
      if (sz > 0) begin
        e = (p == 0) ? ex0[0] : ex1[0];
        if (!pv[p]) last_lat = cyc - e.acc_cyc;
        check({nm, "_result"}, res, e.res);
        check({nm, "_exception"}, 32'(exc), 32'(e.exc));
        check({nm, "_tag"}, 32'(tag), 32'(e.tag));
        if (r) begin
          if (p == 0) void'(ex0.pop_front()); else void'(ex1.pop_front());
          last_consume = cyc;
        end
      end
    end else begin
      check({nm, "_quiet"}, res | 32'(exc) | 32'(tag), 0);
    end
    pv[p] = v; pr[p] = r;
  endtask

  initial begin : monitor
    pv = '{0, 0}; pr = '{0, 0};
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        pv = '{0, 0}; pr = '{0, 0}; in_op = 0;
      end else begin
        check("ready_onehot", 32'(req0_ready & req1_ready), 0);
        check("ctrl_exclusive", 32'(md_ctrl_MULT & md_ctrl_DIV), 0);
        if (md_ctrl_MULT) mult_cycles++;
        if (md_ctrl_DIV) div_cycles++;
        if (timeout) timeout_cycles++;
        if (md_ctrl_MULT || md_ctrl_DIV) in_op = 1;
        if (in_op && busy) begin
          check("operandA", md_operandA, cur_a);
          check("operandB", md_operandB, cur_b);
        end
        if (!busy) in_op = 0;
        rsp_mon(0, rsp0_valid, rsp0_ready, rsp0_result, rsp0_exception, rsp0_tag);
        rsp_mon(1, rsp1_valid, rsp1_ready, rsp1_result, rsp1_exception, rsp1_tag);
      end
    end
  end

  task automatic check_all_zero(input string tg);
    check({tg, "_req_ready"}, 32'({req0_ready, req1_ready}), 0);
    check({tg, "_rsp_valid"}, 32'({rsp0_valid, rsp1_valid}), 0);
    check({tg, "_rsp0_data"}, rsp0_result | 32'(rsp0_exception) | 32'(rsp0_tag), 0);
    check({tg, "_rsp1_data"}, rsp1_result | 32'(rsp1_exception) | 32'(rsp1_tag), 0);
    check({tg, "_operandA"}, md_operandA, 0);
    check({tg, "_operandB"}, md_operandB, 0);
    check({tg, "_ctrl_busy_timeout"}, 32'({md_ctrl_MULT, md_ctrl_DIV, busy, timeout}), 0);
  endtask

  task automatic wait_drain(input string tg, input int budget);
    int n;
    n = 0;
    while ((rq0.size() + rq1.size() + ex0.size() + ex1.size()) != 0 || busy) begin
      @(negedge clock); #1;
      n++;
      if (n > budget) begin
        check({tg, "_drain_cycles"}, n, budget);
        return;
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : main
    int n;
    int rr1_exp[4];
    req0_valid = 0; req0_op = 0; req0_a = '0; req0_b = '0; req0_tag = '0;
    req1_valid = 0; req1_op = 0; req1_a = '0; req1_b = '0; req1_tag = '0;
    rsp0_ready = 0; rsp1_ready = 0;

    // Reset state, with a request already presented on port 0.
    md_lat = 33;
    push_req(0, OP_MULT, 32'd7, -32'sd3, 5'd5, 32'hFFFF_FFEB, 1'b0);
    repeat (3) @(negedge clock);
    #1 check_all_zero("reset");
    @(posedge clock); #2 reset_n = 1'b1;

    // Multiply on port 0 with a slow unit.
    mult_cycles = 0; div_cycles = 0;
    wait_drain("mult0", 200);
    check("mult0_pulse_cycles", mult_cycles, 1);
    check("mult0_div_pulses", div_cycles, 0);

    // Divides on port 1, including divide-by-zero.
    md_lat = 5; mult_cycles = 0; div_cycles = 0;
    push_req(1, OP_DIV, 32'd100, 32'd7, 5'd9, 32'd14, 1'b0);
    push_req(1, OP_DIV, 32'd5, 32'd0, 5'd10, 32'd0, 1'b1);
    wait_drain("div1", 200);
    check("div1_pulse_cycles", div_cycles, 2);
    check("div1_mult_pulses", mult_cycles, 0);

    // Response back-pressure on port 0 while port 1 waits.
    hold0 = 1;
    push_req(0, OP_MULT, 32'd12345, -32'sd2, 5'd3, 32'hFFFF_9F8E, 1'b0);
    n = 0;
    while (!rsp0_valid && n < 100) begin @(negedge clock); #1; n++; end
    check("hold_rsp0_arrived", 32'(rsp0_valid), 1);
    push_req(1, OP_DIV, -32'sd100, 32'd7, 5'd4, 32'hFFFF_FFF2, 1'b0);
    repeat (5) begin
      @(negedge clock); #1;
      check("hold_rsp0_valid", 32'(rsp0_valid), 1);
      check("hold_rsp0_result", rsp0_result, 32'hFFFF_9F8E);
      check("hold_req_ready", 32'({req0_ready, req1_ready}), 0);
    end
    hold0 = 0;
    wait_drain("hold", 200);

    // Earliest capture, then stale ready held over into the next op's guard window.
    stale_mode = 1; md_lat = 3;
    push_req(1, OP_MULT, 32'd3, 32'd4, 5'd1, 32'd12, 1'b0);
    wait_drain("stale_a", 100);
    check("min_latency", last_lat, 3 + GUARD);
    md_lat = 10;
    push_req(1, OP_MULT, 32'd6, 32'd7, 5'd2, 32'd42, 1'b0);
    wait_drain("stale_b", 100);
    stale_mode = 0;

    // Reset in the middle of WAIT abandons the op.
    md_lat = 33;
    push_req(0, OP_DIV, 32'd1000, 32'd10, 5'd7, 32'd100, 1'b0);
    n = 0;
    while (!busy && n < 50) begin @(negedge clock); #1; n++; end
    check("midrst_busy", 32'(busy), 1);
    repeat (6) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midrst");
    ex0.delete(); ex1.delete(); rq0.delete(); rq1.delete();
    repeat (2) @(negedge clock);
    @(posedge clock); #2 reset_n = 1'b1;

    // Both ports valid continuously from reset: strict alternation, nothing lost.
    md_lat = 3; mult_cycles = 0; div_cycles = 0;
    grant_log.delete(); b2b_chk = 1;
    rr1_exp = '{-14, -28, -42, -57};
    for (int i = 0; i < 4; i++) begin
      push_req(0, OP_MULT, 32'(i + 2), -32'sd5, 5'(i), 32'(-5 * (i + 2)), 1'b0);
      push_req(1, OP_DIV, 32'(100 * (i + 1)), -32'sd7, 5'(16 + i), 32'(rr1_exp[i]), 1'b0);
    end
    wait_drain("rr", 400);
    b2b_chk = 0;
    check("rr_grant_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size(); i++) check($sformatf("rr_grant_%0d", i), grant_log[i], i % 2);
    check("rr_mult_pulses", mult_cycles, 4);
    check("rr_div_pulses", div_cycles, 4);

`ifdef MDARB_TIMEOUT_EN
    // Unit never answers: abort with exception and a single timeout pulse.
    never_ready = 1; timeout_cycles = 0;
    push_req(0, OP_MULT, 32'd2, 32'd2, 5'd11, 32'd0, 1'b1);
    wait_drain("timeout", 300);
    check("timeout_pulses", timeout_cycles, 1);
    check("timeout_latency", last_lat, 3 + TIMEOUT);
    never_ready = 0;
`else
    check("timeout_tied_low_cycles", timeout_cycles, 0);
`endif

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multdiv_arbiter.md
# multdiv_arbiter

Shares one multiplier/divider unit between two requesters (e.g. the execute stage and a secondary issue port). It arbitrates round-robin and accepts one operation at a time over a valid/ready handshake. It then sequences the unit: holds the operands, pulses `ctrl_MULT`/`ctrl_DIV` for one cycle, waits for `data_resultRDY`, and returns result, exception and tag to the owning requester. It sits between the pipeline and the `multdiv` instance.

## Interface
- `TAG_W`, 5: width of the requester tag (destination register number).
- `GUARD_CYCLES`, 2: WAIT cycles during which `md_resultRDY` is ignored; masks stale ready from the previous op.
- `TIMEOUT_CYCLES`, 64: WAIT cycles before abort. Used only with `MDARB_TIMEOUT_EN`.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `reqX_valid` in 1 (X=0,1): request present.
- `reqX_ready` out 1: request accepted this cycle when valid&ready.
- `reqX_op` in 1: 0 = multiply, 1 = divide.
- `reqX_a`, `reqX_b` in 32: signed two's-complement operands.
- `reqX_tag` in TAG_W: returned unchanged with the response.
- `rspX_valid` out 1: response held until `rspX_ready`.
- `rspX_ready` in 1: response consumed.
- `rspX_result` out 32: result.
- `rspX_exception` out 1: overflow, divide-by-zero or timeout.
- `rspX_tag` out TAG_W: tag of the owning request.
- `md_operandA`, `md_operandB` out 32: to unit operands.
- `md_ctrl_MULT`, `md_ctrl_DIV` out 1: one-cycle start pulses.
- `md_result` in 32: unit result.
- `md_exception` in 1: unit exception.
- `md_resultRDY` in 1: unit result ready.
- `busy` out 1: state ≠ IDLE.
- `timeout` out 1: one-cycle pulse on abort.

## Operation
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - `reqX_ready` is asserted combinationally for the granted requester only.
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last time wins.
  - `last_grant` resets to 1, so req0 wins first.
  - On handshake: latch op, a, b, tag and owner id, update `last_grant`, go to ISSUE.
- ISSUE (1 cycle): assert `md_ctrl_MULT` (op=0) or `md_ctrl_DIV` (op=1), never both. Go to WAIT.
- `md_operandA`/`md_operandB` are driven from the latched registers at all times and stay stable from ISSUE through RESP.
- WAIT:
  - A counter starts at 0.
  - `md_resultRDY` is ignored while counter < GUARD_CYCLES.
  - Once counter ≥ GUARD_CYCLES, a high `md_resultRDY` captures `md_result` and `md_exception` into the response registers; go to RESP.
- RESP:
  - Only the owner's `rspX_valid` is high; the other response port stays low with zero data.
  - `rspX_valid` and data are held stable until `rspX_ready`; then go to IDLE.
  - No new request is accepted before then.
- Reset, at any time including mid-operation:
  - State → IDLE, `last_grant`=1, counters 0.
  - Every output is 0, including ctrl pulses, ready, rsp, `busy` and `timeout`.
  - An in-flight unit operation is abandoned; its later `resultRDY` is masked by the guard on the next op.

## Timing
- Handshake in cycle N.
- ISSUE pulse in N+1.
- WAIT from N+2.
- `md_resultRDY` sampled in cycle M → `rspX_valid` high in M+1.
- `rspX_ready` in cycle K → IDLE in K+1; earliest next accept is K+1.
- Minimum occupancy: N to N+3+GUARD_CYCLES plus the response cycle.
- A request valid while busy waits with ready low; `reqX_*` must stay stable until accepted.

## Configuration
- `MDARB_TIMEOUT_EN` defined:
  - The WAIT counter saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES without a captured ready: result=0, exception=1, `timeout` pulses for one cycle, go to RESP.
- `MDARB_TIMEOUT_EN` undefined:
  - WAIT never exits without `md_resultRDY`.
  - `timeout` is tied 0.
  - The counter only needs to count to GUARD_CYCLES.

## Structure
- Package `mdarb_pkg`: state encoding (IDLE/ISSUE/WAIT/RESP), `OP_MULT`=0 / `OP_DIV`=1, owner-id constants.
- Sub-module `rr_arb2`: two-input round-robin picker. Inputs: two valids and `last_grant`. Outputs: one-hot grant.
- The top level holds the FSM, operand/tag/response registers and the counter.

## Test plan
- req0 mult a=7, b=-3 (unit model ready after 33 cycles) → `rsp0_result`=0xFFFFFFEB, exception 0, tag echoed; `md_ctrl_MULT` high exactly one cycle.
- req1 div a=100, b=7 → `rsp1_result`=14, exception 0. Then div a=5, b=0 → `rsp1_exception`=1.
- req0 and req1 both valid continuously after reset → grant order 0,1,0,1; no operation lost or duplicated.
- `rsp0_ready` held low 5 cycles → `rsp0_valid` and data stable; both `reqX_ready` low throughout.
- Model holds stale `md_resultRDY`=1 from the previous op → result not captured during the guard cycles; the correct new result is returned.
- `reset_n` low mid-WAIT → all outputs 0 immediately. With `MDARB_TIMEOUT_EN` and a model that never asserts ready → after TIMEOUT_CYCLES, `timeout` pulses and the response shows exception 1, result 0.
